// File: rtl/data_bus_scheduler.sv
// Command encoding shared with the timing controller, followed by the DQ bus
// scheduler. The scheduler turns issued read/write column commands into
// BURST_TIME-beat data windows on the shared DQ bus, using two slots.
package types_def;
  typedef enum logic [2:0] {
    nop_cmd, activate_cmd, read_cmd, write_cmd, precharge_cmd, refresh_all_cmd
  } command;
endpackage

module data_bus_scheduler
  import types_def::*;
#(
  parameter int NO_OF_BURSTS = 4,
  parameter int RD_TO_DATA   = 6,
  parameter int WR_TO_DATA   = 5,
  parameter int BURST_TIME   = 8,
  parameter int DQ_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  command                        cmd_i,
  input  logic [$clog2(NO_OF_BURSTS)-1:0] cmd_index_i,
  output logic                          wr_beat_req_o,
  output logic [$clog2(NO_OF_BURSTS)-1:0] wr_beat_idx_o,
  input  logic [DQ_WIDTH-1:0]           wr_beat_i,
  output logic [DQ_WIDTH-1:0]           dq_o,
  output logic                          dq_oe_o,
  input  logic [DQ_WIDTH-1:0]           dq_i,
  output logic                          rd_beat_valid_o,
  output logic [DQ_WIDTH-1:0]           rd_beat_data_o,
  output logic [$clog2(NO_OF_BURSTS)-1:0] rd_beat_idx_o,
  output logic [$clog2(BURST_TIME)-1:0] beat_cnt_o,
  output logic                          burst_done_o,
  output logic [$clog2(NO_OF_BURSTS)-1:0] done_idx_o,
  output logic                          busy_o,
  output logic                          overlap_err_o
);
  localparam int IW      = $clog2(NO_OF_BURSTS);
  localparam int BW      = $clog2(BURST_TIME);
  // Lead length = cycles spent in LEAD before the slot's first action cycle
  // (write: first beat request, read: first dq_i sample).
  localparam int RD_LEAD = RD_TO_DATA - 1;
  localparam int WR_LEAD = WR_TO_DATA - 2;
  localparam int LMAX    = (RD_LEAD > WR_LEAD) ? RD_LEAD : WR_LEAD;
  localparam int CMAX    = (LMAX > BURST_TIME - 1) ? LMAX : BURST_TIME - 1;
  localparam int CW      = $clog2(CMAX + 1);
  localparam logic [CW-1:0] LAST = CW'(BURST_TIME - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER} slot_state_t;

  slot_state_t     st  [2];
  logic [IW-1:0]   idx [2];
  logic [CW-1:0]   cnt [2];
  logic [1:0]      is_wr;
  logic            old;      // which slot was issued first

  logic [1:0]      act, last, cov, first, drop, free, live;
  logic [CW-1:0]   ld_cnt;
  logic            is_col, in_drop, acc, ovf, sel, asel;

  // Slot decode: window coverage of the next cycle, collision drop, free slot pick
  always_comb begin
    act   = '0;
    last  = '0;
    cov   = '0;
    first = '0;
    free  = '0;
    for (int s = 0; s < 2; s++) begin
      act[s]  = (st[s] == XFER);
      last[s] = act[s] && (cnt[s] == LAST);
      free[s] = (st[s] == IDLE) || last[s];
      // A write's DQ cycle trails its request cycle by one, so every write
      // XFER cycle means the next cycle is on the bus; a read is on the bus
      // during its own XFER cycles.
      cov[s]   = is_wr[s] ? act[s]
                          : ((st[s] == LEAD && cnt[s] == ONE) || (act[s] && cnt[s] != LAST));
      first[s] = is_wr[s] ? (act[s] && cnt[s] == '0)
                          : (st[s] == LEAD && cnt[s] == ONE);
    end
    // Only the younger slot can be dropped; the older one always completes.
    drop[0] = old && first[0] && cov[1];
    drop[1] = !old && first[1] && cov[0];
    live    = act & ~drop;
    asel    = live[1];
    is_col  = (cmd_i == read_cmd) || (cmd_i == write_cmd);
    // With a one-cycle read delay the collision check lands on the issue cycle.
    in_drop = (RD_LEAD == 0) && (cmd_i == read_cmd) && (|cov);
    acc     = is_col && (|free) && !in_drop;
    ovf     = is_col && !acc;
    sel     = !free[0];
    ld_cnt  = (cmd_i == write_cmd) ? CW'(WR_LEAD) : CW'(RD_LEAD);
  end

  assign wr_beat_req_o = live[asel] && is_wr[asel];
  assign wr_beat_idx_o = wr_beat_req_o ? idx[asel] : '0;
  assign busy_o        = (st[0] != IDLE) || (st[1] != IDLE);

  // Slot FSMs: IDLE -> LEAD -> XFER -> IDLE, plus issue-order tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        st[s]  <= IDLE;
        cnt[s] <= '0;
        idx[s] <= '0;
      end
      is_wr <= '0;
      old   <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (drop[s]) begin
          st[s]  <= IDLE;
          cnt[s] <= '0;
        end else begin
          case (st[s])
            LEAD: begin
              if (cnt[s] == ONE) begin
                st[s]  <= XFER;
                cnt[s] <= '0;
              end else begin
                cnt[s] <= cnt[s] - ONE;
              end
            end
            XFER: begin
              if (last[s]) begin
                st[s]  <= IDLE;
                cnt[s] <= '0;
              end else begin
                cnt[s] <= cnt[s] + ONE;
              end
            end
            default: ;
          endcase
        end
        // A slot on its final beat is reloaded in the same cycle.
        if (acc && (sel == s[0])) begin
          is_wr[s] <= (cmd_i == write_cmd);
          idx[s]   <= cmd_index_i;
          cnt[s]   <= ld_cnt;
          st[s]    <= (ld_cnt == '0) ? XFER : LEAD;
        end
      end
      if (acc)
        old <= (!free[~sel] && !drop[~sel]) ? ~sel : sel;
    end
  end

  // Registered DQ drive, read capture, beat numbering and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      dq_o            <= '0;
      dq_oe_o         <= 1'b0;
      rd_beat_valid_o <= 1'b0;
      rd_beat_data_o  <= '0;
      rd_beat_idx_o   <= '0;
      beat_cnt_o      <= '0;
      burst_done_o    <= 1'b0;
      done_idx_o      <= '0;
      overlap_err_o   <= 1'b0;
    end else begin
      dq_o            <= '0;
      dq_oe_o         <= 1'b0;
      rd_beat_valid_o <= 1'b0;
      rd_beat_data_o  <= '0;
      rd_beat_idx_o   <= '0;
      beat_cnt_o      <= '0;
      burst_done_o    <= 1'b0;
      done_idx_o      <= '0;
      if (live[asel]) begin
        beat_cnt_o <= cnt[asel][BW-1:0];
        if (last[asel]) begin
          burst_done_o <= 1'b1;
          done_idx_o   <= idx[asel];
        end
        if (is_wr[asel]) begin
          dq_oe_o <= 1'b1;
          dq_o    <= wr_beat_i;
        end else begin
          rd_beat_valid_o <= 1'b1;
          rd_beat_data_o  <= dq_i;
          rd_beat_idx_o   <= idx[asel];
        end
      end
      if (ovf || (|drop))
        overlap_err_o <= 1'b1;
    end
  end
endmodule
